mem_stage_sram_ctrl: RTL and testbench

- Memory-access stage logic directly upstream of the MEM/WB pipeline register.
- Takes the word address and store data produced by EX and performs 32-bit loads and stores to an external 16-bit SRAM, one half-word at a time.
- Drives the load value (mem_read_value_in of the MEM/WB register).
- Drives ready, which the hazard/freeze logic uses to stall every pipeline register while an access is in flight.

---
 rtl/mem_stage_sram_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: 32-bit loads/stores as two half-word accesses to a 16-bit SRAM.
// Optional one-entry load buffer enabled by defining SRAM_READ_BUF_EN.
module mem_stage_sram_ctrl #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic               is_wr_reg, is_wr_next;
    logic [31:0]        read_data_reg;
    logic [SRAM_AW-1:0] addr_hold_reg;

    logic [31:0]        off;
    logic               req;
    logic               active;
    logic               half;
    logic               last_cnt;
    logic               buf_hit;
    logic               unused_bits;

    assign off         = address - BASE_ADDR;
    assign req         = rd_en | wr_en;
    assign active      = (state_reg == LOW) || (state_reg == HIGH);
    assign half        = (state_reg == HIGH);
    assign last_cnt    = (cnt_reg == 4'd0);
    assign unused_bits = ^{address[1:0], off[31:SRAM_AW], off[1:0]};

`ifdef SRAM_READ_BUF_EN
    logic        buf_valid_reg;
    logic [29:0] buf_tag_reg;
    logic [31:0] buf_data_reg;
    logic        tag_match;

    assign tag_match = buf_valid_reg && (buf_tag_reg == address[31:2]);
    assign buf_hit   = (state_reg == IDLE) && rd_en && !wr_en && tag_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
            buf_data_reg  <= '0;
        end else if (state_reg == IDLE && wr_en && tag_match) begin
            buf_valid_reg <= 1'b0;
        end else if (state_reg == HIGH && last_cnt && !is_wr_reg) begin
            // Request inputs are frozen for the whole access, so address is still the load's tag.
            buf_valid_reg <= 1'b1;
            buf_tag_reg   <= address[31:2];
            buf_data_reg  <= {sram_dq_in, read_data_reg[15:0]};
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        is_wr_next = is_wr_reg;
        ready      = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = !req;
                if (buf_hit) begin
                    ready = 1'b1;
                end else if (req) begin
                    state_next = LOW;
                    cnt_next   = 4'(WAIT_CYCLES - 1);
                    is_wr_next = wr_en;
                end
            end
            LOW: begin
                if (last_cnt) begin
                    state_next = HIGH;
                    cnt_next   = 4'(WAIT_CYCLES - 1);
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            HIGH: begin
                if (last_cnt) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // SRAM pins follow the state directly; the address register only remembers the last one driven.
    always_comb begin
        sram_addr   = addr_hold_reg;
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (active) begin
            sram_addr = {1'b0, off[SRAM_AW-1:2], half};
            if (is_wr_reg) begin
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                sram_dq_out = half ? write_data[31:16] : write_data[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            is_wr_reg     <= 1'b0;
            read_data_reg <= 32'd0;
            addr_hold_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            is_wr_reg <= is_wr_next;
            if (active) begin
                addr_hold_reg <= sram_addr;
            end
            if (state_reg == LOW && last_cnt && !is_wr_reg) begin
                read_data_reg[15:0] <= sram_dq_in;
            end
            if (state_reg == HIGH && last_cnt && !is_wr_reg) begin
                read_data_reg[31:16] <= sram_dq_in;
            end
`ifdef SRAM_READ_BUF_EN
            if (buf_hit) begin
                read_data_reg <= buf_data_reg;
            end
`endif
        end
    end

    assign read_data = read_data_reg;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed cases then random loads/stores against a
// transaction-level memory model (also models the read buffer when SRAM_READ_BUF_EN is defined).
module tb_mem_stage_sram_ctrl;
    localparam int W  = 2;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en, wr_en;
    logic [31:0]   address, write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n;

    int checks = 0;
    int errors = 0;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // External SRAM device
    logic [15:0] sram_mem [0:(1<<AW)-1];
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

    // Reference model state
    logic [15:0] ref_mem [int];
    logic [31:0] exp_rd;
    int          exp_last;
    bit          bv;
    logic [29:0] btag;
    logic [31:0] bdata;
    int          hits = 0;

    function automatic logic [15:0] fill(input int h);
        logic [31:0] hv;
        hv = h;
        return hv[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] rm(input int h);
        return ref_mem.exists(h) ? ref_mem[h] : fill(h);
    endfunction

    function automatic int hw(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'(((off >> 2) % 32'h10000) * 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 0; wr_en = 0;
            #1;
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
            chk("idle_oe", 32'(sram_dq_oe), 32'd0);
            chk("idle_rdata", read_data, exp_rd);
            chk("idle_addr", 32'(sram_addr), 32'(exp_last));
            @(negedge clk); #1;
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int  h0;
        bit  store, hit;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        #1;
        store = wr;
        h0 = hw(a);
        hit = 0;
`ifdef SRAM_READ_BUF_EN
        hit = rd && !wr && bv && (btag == a[31:2]);
        if (wr && bv && btag == a[31:2]) bv = 0;
`endif
        if (hit) begin
            hits++;
            chk("hit_ready", 32'(ready), 32'd1);
            chk("hit_we_n", 32'(sram_we_n), 32'd1);
            chk("hit_oe", 32'(sram_dq_oe), 32'd0);
            chk("hit_addr", 32'(sram_addr), 32'(exp_last));
            @(negedge clk); #1;
            exp_rd = bdata;
            chk("hit_rdata", read_data, exp_rd);
            chk("hit_addr2", 32'(sram_addr), 32'(exp_last));
            $display("txn load hit  addr=%h data=%h", a, exp_rd);
            return;
        end
        chk("req_ready0", 32'(ready), 32'd0);
        for (int k = 1; k <= 2*W; k++) begin
            bit hi;
            @(negedge clk); #1;
            hi = (k > W);
            chk("acc_ready", 32'(ready), 32'd0);
            chk("acc_addr", 32'(sram_addr), 32'(h0 + int'(hi)));
            chk("acc_we_n", 32'(sram_we_n), 32'(!store));
            chk("acc_oe", 32'(sram_dq_oe), 32'(store));
            if (store) chk("acc_dq", 32'(sram_dq_out), hi ? 32'(d[31:16]) : 32'(d[15:0]));
        end
        @(negedge clk); #1;
        chk("done_ready", 32'(ready), 32'd1);
        if (store) begin
            ref_mem[h0]     = d[15:0];
            ref_mem[h0 + 1] = d[31:16];
        end else begin
            exp_rd = {rm(h0 + 1), rm(h0)};
`ifdef SRAM_READ_BUF_EN
            bv = 1; btag = a[31:2]; bdata = exp_rd;
`endif
        end
        chk("done_rdata", read_data, exp_rd);
        exp_last = h0 + 1;
        $display("txn %s addr=%h wdata=%h rdata=%h", store ? "store" : "load ", a, d, exp_rd);
        @(negedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) sram_mem[i] = fill(i);
        rst = 0; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
        exp_rd = 0; exp_last = 0; bv = 0; btag = 0; bdata = 0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_dq", 32'(sram_dq_out), 32'd0);
        rst = 1;
        @(negedge clk); #1;
        idle(3);

        access(0, 1, 32'd1028, 32'hDEADBEEF);
        idle(1);
        access(1, 0, 32'd1028, 32'h0);
        chk("load_value", exp_rd, 32'hDEADBEEF);
        idle(3);
        access(1, 0, 32'd1028, 32'h0);
`ifdef SRAM_READ_BUF_EN
        chk("hit_count", 32'(hits), 32'd1);
`endif
        access(0, 1, 32'd1028, 32'hCAFEF00D);
        access(1, 0, 32'd1028, 32'h0);
        chk("reload_value", read_data, 32'hCAFEF00D);
        idle(1);
        access(1, 1, 32'd1024, 32'h12345678);
        idle(1);
        access(0, 1, 32'd0, 32'hA5A50F0F);
        access(1, 0, 32'd0, 32'h0);
        idle(1);

        // Reset during the second HIGH cycle of a load
        rd_en = 1; wr_en = 0; address = 32'd1032; #1;
        for (int k = 1; k <= 2*W; k++) begin @(negedge clk); #1; end
        rst = 0; #1;
        exp_rd = 0; exp_last = 0; bv = 0;
        chk("mid_rst_rdata", read_data, 32'd0);
        chk("mid_rst_addr", 32'(sram_addr), 32'd0);
        chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        @(negedge clk); #1;
        rst = 1; #1;
        chk("rel_ready", 32'(ready), 32'd0);
        $display("txn reset mid-load");
        idle(1);
        access(1, 0, 32'd1028, 32'h0);
        idle(1);

        for (int t = 0; t < 30; t++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = 32'd1024 + 32'(4 * $urandom_range(0, 7));
            access(kind != 1, kind != 0, a, $urandom);
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
